serial_frame_receiver: RTL
==========================

# serial_frame_receiver

- Receives framed serial bits and assembles them into parallel words.
- Frame format: start bit, WIDTH data bits LSB-first, optional parity bit, stop bit.
- Output is a one-entry buffer with a valid/ready handshake.
- Sits at the far end of a parallel-load/shift-out serial link and recovers the words that link transmits; parity, framing and overrun errors are reported as one-cycle pulses.

## Interface
Parameters:
- WIDTH, 4, data bits per frame (≥2)
- PARITY_EN, 1, parity bit present after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports (reset: asynchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- bit_en  in  1  bit strobe; serial_in is sampled only on cycles where bit_en=1
- serial_in  in  1  serial line; idles high
- out_data  out  WIDTH  received word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- parity_err  out  1  one-cycle pulse: parity mismatch, frame dropped
- frame_err  out  1  one-cycle pulse: stop bit sampled 0, frame dropped
- overrun  out  1  one-cycle pulse: good frame completed while buffer full, new frame dropped
- busy  out  1  FSM not in IDLE

## Operation
FSM states: IDLE, DATA, PARITY, STOP, WAIT_HIGH. All transitions happen only on cycles with bit_en=1; with bit_en=0 the FSM, shift register and bit counter hold.
- IDLE:
  - serial_in=0 → DATA, bit counter cleared.
  - serial_in=1 → stay in IDLE.
- DATA:
  - Each strobe: shreg <= {serial_in, shreg[WIDTH-1:1]}, counter increments.
  - After WIDTH strobes: → PARITY if PARITY_EN, else → STOP.
- PARITY:
  - Sample the parity bit.
  - Mismatch flag = (^shreg ^ serial_in ^ PARITY_ODD) != 0. Latch the flag → STOP.
- STOP:
  - serial_in=0 → frame_err pulse, frame dropped, → WAIT_HIGH.
  - serial_in=1 with parity mismatch → parity_err pulse, frame dropped, → IDLE.
  - Otherwise the frame is good → IDLE.
- WAIT_HIGH:
  - Stay until serial_in=1 is sampled, then → IDLE. A held-low line (break) is never taken as a new start bit.
- Delivering a good frame:
  - Buffer empty, or out_valid && out_ready in the same cycle: out_data <= shreg, out_valid <= 1.
  - Buffer full and not consumed that cycle: overrun pulse, out_data unchanged.
- Consumption: out_valid && out_ready with no load in that cycle → out_valid <= 0.
- parity_err and frame_err cannot both pulse for one frame; frame_err takes priority.

## Timing
- Reset values: out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset clears state to IDLE, shreg and counter to 0.
- Reset mid-frame aborts the frame; no error pulse is generated.
- Frame length: 2+WIDTH+PARITY_EN strobes.
- out_valid and the error/overrun pulses are registered at the clock edge that samples the stop bit (visible the following cycle). Error/overrun pulses are high for exactly one clk, regardless of bit_en.
- out_data stays stable while out_valid && !out_ready.
- out_ready is ignored when out_valid=0.
- A back-to-back start bit on the first strobe after STOP is accepted; zero idle bits are required.
- busy rises the cycle after the start-bit strobe and falls the cycle after the stop-bit strobe (or after WAIT_HIGH exits).

## Structure
- Package serial_frame_pkg:
  - State enum (IDLE, DATA, PARITY, STOP, WAIT_HIGH).
  - Bit-counter width constant $clog2(WIDTH+1).
  - Parity function calc_parity(data, odd).
- One sub-module, rx_shift_reg: WIDTH-bit right-shift register with enable and synchronous clear. The FSM, counter and output buffer live in the top level.

## Test plan
All scenarios use WIDTH=4, PARITY_EN=1, PARITY_ODD=0, bit_en=1 every cycle unless stated.
- Reset, then serial_in held 1 for 10 cycles → all outputs 0, busy=0.
- Send word 4'hA: bits 0 | 0,1,0,1 | 0 | 1, out_ready=1 → out_data=4'hA, out_valid=1 for one cycle, no error pulses.
- Send 4'h3 with parity bit 1 → parity_err pulse; out_valid stays 0; the next frame 4'h5 is received correctly.
- Send 4'h6 with stop bit 0, line held 0 for 5 more strobes, then 1, then frame 4'h9 → one frame_err pulse; no false start during the low period; 4'h9 delivered.
- out_ready=0, send 4'h1 then 4'h2 back-to-back → out_data=4'h1, overrun pulse at the second stop bit. Repeat with out_ready=1 on the cycle 4'h2 completes → out_data=4'h2, no overrun.
- bit_en=1 only every 4th cycle, and reset asserted at data bit 2 of a frame → the 4'hC frame sent with the sparse strobes is received correctly; the reset frame returns outputs to 0; the next frame 4'hF is received correctly.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared state encoding and helpers for the serial frame receiver
package serial_frame_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic calc_parity(input logic [31:0] data, input logic odd);
        return ^data ^ odd;
    endfunction
endpackage

// File: rtl/serial_frame_receiver_rx_shift_reg.sv
// rx_shift_reg: right-shift register, new bit enters at the MSB so LSB-first data lands in order
module rx_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= {d, q[WIDTH-1:1]};
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: deframes start/data/parity/stop bits into a one-entry valid/ready buffer
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);

    state_e           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_shreg, r_data;
    logic             r_par_err, r_valid, r_parity_err, r_frame_err, r_overrun;
    logic             w_start, w_shift, w_last, w_stop, w_good;

    assign w_start = bit_en && r_state == IDLE && !serial_in;
    assign w_shift = bit_en && r_state == DATA;
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign w_stop  = bit_en && r_state == STOP;
    assign w_good  = w_stop && serial_in && !r_par_err;

    rx_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk  (clk),
        .reset(reset),
        .en   (w_shift),
        .clr  (w_start),
        .d    (serial_in),
        .q    (w_shreg)
    );

    always_comb begin
        w_next = r_state;
        if (bit_en)
            case (r_state)
                IDLE:      w_next = serial_in ? IDLE : DATA;
                DATA:      w_next = !w_last ? DATA : (PARITY_EN ? PARITY : STOP);
                PARITY:    w_next = STOP;
                STOP:      w_next = serial_in ? IDLE : WAIT_HIGH;
                WAIT_HIGH: w_next = serial_in ? IDLE : WAIT_HIGH;
                default:   w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_par_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) r_cnt <= '0;
            else if (w_shift) r_cnt <= r_cnt + CW'(1);
            if (w_start) r_par_err <= 1'b0;
            else if (bit_en && r_state == PARITY)
                r_par_err <= calc_parity(32'(w_shreg), PARITY_ODD) ^ serial_in;
        end

    // a good frame may reload the buffer in the same cycle the old word is consumed
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= w_stop && serial_in && r_par_err;
            r_frame_err  <= w_stop && !serial_in;
            r_overrun    <= w_good && r_valid && !out_ready;
            if (w_good && (!r_valid || out_ready)) begin
                r_data  <= w_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) r_valid <= 1'b0;
        end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_state != IDLE;
endmodule
